clock_and_set: RTL and testbench
================================

CLOCK_AND_SET -- requirements
Module: clock_and_set

Interface
REQ-001 Parameter TICK_DIV, default 1: clk cycles per one-second tick, legal range >= 1.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 cr  input  1  reset, synchronous and active-high.
REQ-004 clock_set_select  input  2  mode: 00 run, 01 adjust second, 10 adjust minute, 11 adjust hour.
REQ-005 set_confirm  input  1  adjust strobe; level input, rising-edge sensitive.
REQ-006 hour  output  8  BCD hour 00..23; [7:4] tens, [3:0] units.
REQ-007 minute  output  8  BCD minute 00..59; same packing.
REQ-008 second  output  8  BCD second 00..59; same packing.

Function
REQ-009 The block SHALL drive all outputs from registers, with no combinational path from inputs to outputs.
REQ-010 The prescaler SHALL count 0..TICK_DIV-1 and SHALL assert an internal tick in the cycle it equals TICK_DIV-1, then wrap to 0.
REQ-011 With TICK_DIV=1, a tick SHALL occur every cycle.
REQ-012 On a tick, second SHALL increment in BCD: units 9 -> 0 with tens +1; 59 -> 00 with carry to minute.
REQ-013 Minute SHALL count the same way: 59 -> 00 with carry to hour.
REQ-014 Hour SHALL count 00..23; 23 -> 00, so 23:59:59 -> 00:00:00 on one tick.
REQ-015 set_confirm SHALL be registered each cycle; a set edge is set_confirm=1 while its registered value is 0.
REQ-016 A set edge while clock_set_select=01 SHALL increment second by one, wrapping 59 -> 00, with no carry to minute.
REQ-017 A set edge while clock_set_select=10 SHALL increment minute by one, wrapping 59 -> 00, with no carry to hour.
REQ-018 A set edge while clock_set_select=11 SHALL increment hour by one, wrapping 23 -> 00.
REQ-019 A set edge while clock_set_select=00 SHALL be ignored.
REQ-020 Holding set_confirm high for any number of cycles SHALL produce exactly one increment.
REQ-021 If a set edge and a tick coincide, the set increment SHALL apply and the entire tick SHALL be discarded; the prescaler still wraps.
REQ-022 A change of clock_set_select SHALL take effect on the same rising edge it is sampled.
REQ-023 Fields SHALL never hold non-BCD or out-of-range values.

Reset
REQ-024 When cr=1 at a rising edge, hour, minute, second and the prescaler SHALL all become 0.
REQ-025 During reset, the set_confirm register SHALL load the current set_confirm value, so a level held through reset creates no edge.
REQ-026 cr SHALL override tick and set edges in the same cycle, including reset during adjust mode.
REQ-027 The first tick after reset release SHALL occur TICK_DIV cycles later; with TICK_DIV=1, second=01 after the first non-reset edge.

Configuration
REQ-028 Macro CLOCK_AND_SET_HOLD_EN SHALL control counting in adjust modes.
REQ-029 With CLOCK_AND_SET_HOLD_EN defined, ticks SHALL be suppressed and the prescaler held while clock_set_select != 00; counting resumes from the held prescaler value on return to 00.
REQ-030 Without CLOCK_AND_SET_HOLD_EN, timekeeping SHALL continue in all modes, subject to REQ-021.

Verification
REQ-031 Run rollover, TICK_DIV=1: pulse cr, hold mode 00, run 60 cycles -> 00:01:00; run 86400 cycles total -> 00:00:00, with 23:59:59 after 86399.
REQ-032 Minute adjust, HOLD_EN defined: at 00:10:00, select 10, hold set_confirm high 50 cycles, then low -> exactly 00:11:00, with no seconds advancing in mode 10.
REQ-033 Hour wrap: at 23:05:30 with HOLD_EN, select 11 and one set edge -> 00:05:30.
REQ-034 Reset mid-adjust: select 10, set_confirm high, assert cr for 1 cycle while set_confirm stays high -> 00:00:00 and no increment after release.
REQ-035 No-hold build, TICK_DIV=4, mode 01: seconds keep advancing every 4 cycles; a set edge coinciding with a tick gives a net +1 second.
REQ-036 Mode 00 with set edges: 10 set edges produce no change beyond normal ticking.

Source files
------------

// File: rtl/clock_and_set.sv
// BCD hour/minute/second timekeeper with a prescaled one-second tick and edge-strobed field adjust.
// Define CLOCK_AND_SET_HOLD_EN to freeze timekeeping (tick and prescaler) while an adjust mode is selected.
module clock_and_set #(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       cr,
    input  logic [1:0] clock_set_select,
    input  logic       set_confirm,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] presc;
    logic          set_q;
    logic          run_mode;
    logic          count_en;
    logic          tick;
    logic          set_edge;
    logic          adjust;

    assign run_mode = (clock_set_select == 2'b00);
`ifdef CLOCK_AND_SET_HOLD_EN
    assign count_en = run_mode;
`else
    assign count_en = 1'b1;
`endif
    assign tick     = count_en && (presc == LAST);
    assign set_edge = set_confirm && !set_q;
    // Set edges only matter in an adjust mode; in run mode they neither adjust nor steal a tick.
    assign adjust   = set_edge && !run_mode;

    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] inc_mod24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)            r = 8'h00;
        else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
        else                       r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    always_ff @(posedge clk) begin
        // Loaded even in reset so a level held through reset does not look like an edge.
        set_q <= set_confirm;
        if (cr) begin
            presc  <= '0;
            hour   <= 8'h00;
            minute <= 8'h00;
            second <= 8'h00;
        end else begin
            if (count_en) begin
                if (presc == LAST) presc <= '0;
                else               presc <= presc + 1'b1;
            end
            // An adjust increment wins over a coincident tick; that tick is dropped entirely.
            if (adjust) begin
                case (clock_set_select)
                    2'b01:   second <= inc_mod60(second);
                    2'b10:   minute <= inc_mod60(minute);
                    2'b11:   hour   <= inc_mod24(hour);
                    default: ;
                endcase
            end else if (tick) begin
                second <= inc_mod60(second);
                if (second == 8'h59) begin
                    minute <= inc_mod60(minute);
                    if (minute == 8'h59) hour <= inc_mod24(hour);
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_and_set.sv
// Scoreboard bench for clock_and_set: a TICK_DIV=1 and a TICK_DIV=4 instance driven by parallel directed threads.
module tb_clock_and_set;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       cr_f = 1'b0, sc_f = 1'b0;
    logic [1:0] sel_f = 2'b00;
    logic [7:0] hour_f, minute_f, second_f;
    logic       cr_s = 1'b0, sc_s = 1'b0;
    logic [1:0] sel_s = 2'b00;
    logic [7:0] hour_s, minute_s, second_s;

    clock_and_set #(.TICK_DIV(1)) u_fast (
        .clk(clk), .cr(cr_f), .clock_set_select(sel_f), .set_confirm(sc_f),
        .hour(hour_f), .minute(minute_f), .second(second_f)
    );

    clock_and_set #(.TICK_DIV(4)) u_slow (
        .clk(clk), .cr(cr_s), .clock_set_select(sel_s), .set_confirm(sc_s),
        .hour(hour_s), .minute(minute_s), .second(second_s)
    );

`ifdef CLOCK_AND_SET_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    // Entry: bit 24 selects the slow instance, [23:0] is expected {hour, minute, second}.
    logic [24:0] exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_t(input bit slow, input logic [23:0] t, input string nm);
        exp_q.push_back({slow, t});
        name_q.push_back(nm);
    endtask

    task automatic reset_f();
        cr_f = 1'b1; step(1); cr_f = 1'b0;
    endtask

    task automatic pulse_f(input int n);
        repeat (n) begin
            sc_f = 1'b1; step(1);
            sc_f = 1'b0; step(1);
        end
    endtask

    // Monitor: inputs and pushes change at the falling edge, outputs at the rising edge.
    initial begin
        logic [24:0] e;
        logic [23:0] act;
        string       nm;
        forever begin
            @(negedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = e[24] ? {hour_s, minute_s, second_s} : {hour_f, minute_f, second_f};
                checks++;
                if (act !== e[23:0]) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", nm, act, e[23:0]);
                end
            end
        end
    end

    task automatic fast_thread();
        // Free-running rollover
        reset_f();
        expect_t(0, 24'h000000, "fast_reset");
        step(1);     expect_t(0, 24'h000001, "first_tick");
        step(59);    expect_t(0, 24'h000100, "one_minute");
        step(86339); expect_t(0, 24'h235959, "day_end");
        step(1);     expect_t(0, 24'h000000, "day_wrap");
        // Ten set edges in run mode change nothing beyond ticking
        pulse_f(10); expect_t(0, 24'h000020, "run_mode_sets");

        // Hour adjust and 23 -> 00 wrap
        reset_f(); sel_f = 2'b11;
        pulse_f(23); expect_t(0, HOLD ? 24'h230000 : 24'h230023, "hour_adj_23");
        pulse_f(1);  expect_t(0, HOLD ? 24'h000000 : 24'h000024, "hour_wrap");

        // Minute adjust wrap without carry into hour
        reset_f(); sel_f = 2'b10;
        pulse_f(59); expect_t(0, HOLD ? 24'h005900 : 24'h005959, "min_adj_59");
        pulse_f(1);  expect_t(0, HOLD ? 24'h000000 : 24'h000100, "min_wrap");

        // Second adjust
        reset_f(); sel_f = 2'b01;
        pulse_f(3);  expect_t(0, HOLD ? 24'h000003 : 24'h000006, "sec_adj");

        // Long set_confirm hold gives one increment
        sel_f = 2'b00; reset_f();
        step(600);   expect_t(0, 24'h001000, "at_ten_min");
        sel_f = 2'b10; sc_f = 1'b1;
        step(50);    expect_t(0, HOLD ? 24'h001100 : 24'h001149, "held_set");
        sc_f = 1'b0;
        step(1);     expect_t(0, HOLD ? 24'h001100 : 24'h001150, "held_release");

        // Reset in adjust mode with set_confirm held through it
        sc_f = 1'b1;
        step(2);     expect_t(0, HOLD ? 24'h001200 : 24'h001251, "pre_reset_adj");
        cr_f = 1'b1;
        step(1);     expect_t(0, 24'h000000, "reset_mid_adj");
        cr_f = 1'b0;
        step(5);     expect_t(0, HOLD ? 24'h000000 : 24'h000005, "no_edge_after_reset");
        sc_f = 1'b0; sel_f = 2'b00;
        step(1);
    endtask

    task automatic slow_thread();
        cr_s = 1'b1; step(1); cr_s = 1'b0;
        expect_t(1, 24'h000000, "slow_reset");
        step(3);  expect_t(1, 24'h000000, "slow_pre_tick");
        step(1);  expect_t(1, 24'h000001, "slow_first_tick");
        sel_s = 2'b01;
        step(8);  expect_t(1, HOLD ? 24'h000001 : 24'h000003, "slow_mode01_run");
        step(3);
        sc_s = 1'b1;
        step(1);  expect_t(1, HOLD ? 24'h000002 : 24'h000004, "set_vs_tick");
        sc_s = 1'b0; sel_s = 2'b00;
        step(3);  expect_t(1, HOLD ? 24'h000002 : 24'h000004, "slow_resume_wait");
        step(1);  expect_t(1, HOLD ? 24'h000003 : 24'h000005, "slow_resume_tick");
    endtask

    initial begin
        fork
            fast_thread();
            slow_thread();
        join
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
